// File: rtl/uart_io_bridge.sv
// uart_io_bridge
//   Responder for the exec-stage UART request handshake. A write request of
//   1-4 bytes is serialised into a byte stream toward the UART transmitter.
//   Bytes from the UART receiver are buffered in a circular FIFO and assembled
//   into right-aligned, zero-extended 1-4 byte read responses. The read and
//   write paths are independent and may be busy at the same time.
//
//   Compile-time option: define UART_BIG_ENDIAN_EN to send the most significant
//   selected write byte first, and to shift read bytes in from the right so
//   the first received byte ends up most significant. By default both
//   directions are LSB first. Handshake timing is the same either way.
//
// Parameters
//   RX_DEPTH_LOG2  log2 of RX FIFO depth (default 4 -> 16 entries)
//
// Ports
//   clk           system clock, all logic on rising edge
//   rst           synchronous active-high reset
//   uart_wenable  one-cycle write request
//   uart_wsz      write size, bytes = uart_wsz + 1
//   uart_wd       write data, right-aligned
//   uart_wdone    one-cycle pulse, write complete
//   uart_renable  one-cycle read request
//   uart_rsz      read size, bytes = uart_rsz + 1
//   uart_rd       read data, right-aligned, zero-extended, held until next rdone
//   uart_rdone    one-cycle pulse, uart_rd valid
//   tx_data       byte to transmitter
//   tx_valid      tx_data valid
//   tx_ready      transmitter accepts byte when tx_valid && tx_ready
//   rx_data       byte from receiver
//   rx_valid      one-cycle strobe, rx_data valid
//   rx_overrun    sticky, a received byte was dropped (cleared by rst only)
//
// Write FSM
//   state   | meaning
//   W_IDLE  | waiting for uart_wenable
//   W_SEND  | presenting bytes to the transmitter
//   W_DONE  | uart_wdone high for one cycle
// Read FSM
//   state     | meaning
//   R_IDLE    | waiting for uart_renable
//   R_COLLECT | popping one FIFO byte per cycle while non-empty
//   R_DONE    | uart_rd updated, uart_rdone high for one cycle

module uart_io_bridge #(
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  input  logic [1:0]  uart_rsz,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_overrun
);

  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] PTR_ONE = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_DONE} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_COLLECT, R_DONE} rstate_t;

  // ---------------- write path ----------------
  wstate_t     wst_q, wst_d;
  logic [31:0] wsr_q, wsr_d;        // bytes still to be sent, next byte at the head
  logic [2:0]  wcnt_q, wcnt_d;      // bytes remaining including the one on tx_data
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        wdone_q, wdone_d;

  logic [31:0] w_align;
  logic [7:0]  w_head_new, w_head_cur;
  logic [31:0] w_rest_new, w_rest_cur;

  // Head/rest split of the shift register. In big-endian mode the selected
  // bytes are first left-justified so the head is always bits [31:24].
  always_comb begin
`ifdef UART_BIG_ENDIAN_EN
    w_align    = uart_wd << {(2'd3 - uart_wsz), 3'b000};
    w_head_new = w_align[31:24];
    w_rest_new = {w_align[23:0], 8'h00};
    w_head_cur = wsr_q[31:24];
    w_rest_cur = {wsr_q[23:0], 8'h00};
`else
    w_align    = uart_wd;
    w_head_new = w_align[7:0];
    w_rest_new = {8'h00, w_align[31:8]};
    w_head_cur = wsr_q[7:0];
    w_rest_cur = {8'h00, wsr_q[31:8]};
`endif
  end

  always_comb begin
    wst_d      = wst_q;
    wsr_d      = wsr_q;
    wcnt_d     = wcnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    wdone_d    = 1'b0;
    case (wst_q)
      W_IDLE: begin
        if (uart_wenable) begin
          wst_d      = W_SEND;
          wcnt_d     = {1'b0, uart_wsz} + 3'd1;
          tx_valid_d = 1'b1;
          tx_data_d  = w_head_new;
          wsr_d      = w_rest_new;
        end
      end
      W_SEND: begin
        if (tx_ready) begin
          if (wcnt_q == 3'd1) begin
            wst_d      = W_DONE;
            tx_valid_d = 1'b0;
            wdone_d    = 1'b1;
          end else begin
            tx_data_d = w_head_cur;
            wsr_d     = w_rest_cur;
            wcnt_d    = wcnt_q - 3'd1;
          end
        end
      end
      W_DONE:  wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q      <= W_IDLE;
      wsr_q      <= 32'h0;
      wcnt_q     <= 3'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      wdone_q    <= 1'b0;
    end else begin
      wst_q      <= wst_d;
      wsr_q      <= wsr_d;
      wcnt_q     <= wcnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wdone_q    <= wdone_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign uart_wdone = wdone_q;

  // ---------------- RX FIFO ----------------
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]               mem [DEPTH];
  logic [RX_DEPTH_LOG2:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic                     overrun_q, overrun_d;
  logic                     fifo_empty, fifo_full, push, pop;
  logic [7:0]               fifo_head;

  rstate_t     rst_q, rst_d;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[RX_DEPTH_LOG2] != rptr_q[RX_DEPTH_LOG2]) &&
                      (wptr_q[RX_DEPTH_LOG2-1:0] == rptr_q[RX_DEPTH_LOG2-1:0]);
  assign fifo_head  = mem[rptr_q[RX_DEPTH_LOG2-1:0]];

  // Pop only sees bytes stored on an earlier cycle, so a byte arriving into an
  // empty FIFO is never forwarded in the same cycle.
  assign pop  = (rst_q == R_COLLECT) && !fifo_empty;
  assign push = rx_valid && (!fifo_full || pop);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    overrun_d = overrun_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (rx_valid && fifo_full && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[RX_DEPTH_LOG2-1:0]] <= rx_data;
  end

  // ---------------- read path ----------------
  logic [31:0] asm_q, asm_d;
  logic [2:0]  rcnt_q, rcnt_d;      // bytes still to pop
  logic [1:0]  ridx_q, ridx_d;      // byte lane for the next pop
  logic [31:0] rd_q, rd_d;
  logic        rdone_q, rdone_d;

  always_comb begin
    rst_d   = rst_q;
    asm_d   = asm_q;
    rcnt_d  = rcnt_q;
    ridx_d  = ridx_q;
    rd_d    = rd_q;
    rdone_d = 1'b0;
    case (rst_q)
      R_IDLE: begin
        if (uart_renable) begin
          rst_d  = R_COLLECT;
          rcnt_d = {1'b0, uart_rsz} + 3'd1;
          ridx_d = 2'd0;
          asm_d  = 32'h0;
        end
      end
      R_COLLECT: begin
        if (pop) begin
`ifdef UART_BIG_ENDIAN_EN
          asm_d = {asm_q[23:0], fifo_head};
`else
          asm_d[{ridx_q, 3'b000} +: 8] = fifo_head;
`endif
          ridx_d = ridx_q + 2'd1;
          rcnt_d = rcnt_q - 3'd1;
          if (rcnt_q == 3'd1) begin
            rst_d   = R_DONE;
            rd_d    = asm_d;
            rdone_d = 1'b1;
          end
        end
      end
      R_DONE:  rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q     <= R_IDLE;
      asm_q     <= 32'h0;
      rcnt_q    <= 3'd0;
      ridx_q    <= 2'd0;
      rd_q      <= 32'h0;
      rdone_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      rst_q     <= rst_d;
      asm_q     <= asm_d;
      rcnt_q    <= rcnt_d;
      ridx_q    <= ridx_d;
      rd_q      <= rd_d;
      rdone_q   <= rdone_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign uart_rd    = rd_q;
  assign uart_rdone = rdone_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_io_bridge.sv
module tb_uart_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_wenable;
  logic [1:0]  uart_wsz;
  logic [31:0] uart_wd;
  logic        uart_wdone;
  logic        uart_renable;
  logic [1:0]  uart_rsz;
  logic [31:0] uart_rd;
  logic        uart_rdone;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overrun;

  int n_checks = 0;
  int n_errors = 0;

  uart_io_bridge #(.RX_DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_wenable (uart_wenable),
    .uart_wsz     (uart_wsz),
    .uart_wd      (uart_wd),
    .uart_wdone   (uart_wdone),
    .uart_renable (uart_renable),
    .uart_rsz     (uart_rsz),
    .uart_rd      (uart_rd),
    .uart_rdone   (uart_rdone),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick;
    rx_valid = 1'b0;
  endtask

  // expb holds the expected transmit order, byte i in expb[8i+7:8i].
  task automatic do_write(input logic [1:0] sz, input logic [31:0] wd,
                          input int stall, input logic [31:0] expb);
    tx_ready     = 1'b0;
    uart_wenable = 1'b1;
    uart_wsz     = sz;
    uart_wd      = wd;
    tick;
    uart_wenable = 1'b0;
    for (int i = 0; i <= int'(sz); i++) begin
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, expb[8*i +: 8]});
        check("stall_wdone", {31'd0, uart_wdone}, 32'd0);
        tick;
      end
      tx_ready = 1'b1;
      check("tx_valid", {31'd0, tx_valid}, 32'd1);
      check("tx_data", {24'd0, tx_data}, {24'd0, expb[8*i +: 8]});
      check("wdone_early", {31'd0, uart_wdone}, 32'd0);
      tick;
    end
    tx_ready = 1'b0;
    check("tx_valid_off", {31'd0, tx_valid}, 32'd0);
    check("wdone", {31'd0, uart_wdone}, 32'd1);
    tick;
    check("wdone_once", {31'd0, uart_wdone}, 32'd0);
  endtask

  // Assumes at least sz+1 bytes already buffered.
  task automatic do_read(input logic [1:0] sz, input logic [31:0] exp);
    uart_renable = 1'b1;
    uart_rsz     = sz;
    tick;
    uart_renable = 1'b0;
    for (int i = 0; i <= int'(sz); i++) begin
      check("rdone_early", {31'd0, uart_rdone}, 32'd0);
      tick;
    end
    check("rdone", {31'd0, uart_rdone}, 32'd1);
    check("rd", uart_rd, exp);
    tick;
    check("rdone_once", {31'd0, uart_rdone}, 32'd0);
    check("rd_hold", uart_rd, exp);
  endtask

  logic [31:0] exp_w4, exp_w2, exp_r3;

  initial begin
`ifdef UART_BIG_ENDIAN_EN
    exp_w4 = 32'h44332211;   // send order 11,22,33,44
    exp_w2 = 32'h0000EFBE;   // send order BE,EF
    exp_r3 = 32'h00A55AFF;
`else
    exp_w4 = 32'h11223344;   // send order 44,33,22,11
    exp_w2 = 32'h0000BEEF;   // send order EF,BE
    exp_r3 = 32'h00FF5AA5;
`endif
    rst = 1'b1; uart_wenable = 1'b0; uart_wsz = 2'd0; uart_wd = 32'h0;
    uart_renable = 1'b0; uart_rsz = 2'd0; tx_ready = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0;
    tick;
    tick;
    check("rst_wdone", {31'd0, uart_wdone}, 32'd0);
    check("rst_rdone", {31'd0, uart_rdone}, 32'd0);
    check("rst_rd", uart_rd, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    rst = 1'b0;
    tick;

    do_write(2'd3, 32'h11223344, 0, exp_w4);
    do_write(2'd3, 32'h11223344, 5, exp_w4);
    do_write(2'd1, 32'hDEADBEEF, 0, exp_w2);

    push_byte(8'hA5);
    push_byte(8'h5A);
    push_byte(8'hFF);
    do_read(2'd2, exp_r3);

    // read on an empty FIFO waits for the byte
    uart_renable = 1'b1;
    uart_rsz     = 2'd0;
    tick;
    uart_renable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("empty_wait", {31'd0, uart_rdone}, 32'd0);
      tick;
    end
    push_byte(8'h7E);
    check("late_rdone_early", {31'd0, uart_rdone}, 32'd0);
    tick;
    check("late_rdone", {31'd0, uart_rdone}, 32'd1);
    check("late_rd", uart_rd, 32'h0000007E);
    tick;

    // push and pop together while full: no overrun, byte is kept
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check("full_no_ovr", {31'd0, rx_overrun}, 32'd0);
    uart_renable = 1'b1;
    uart_rsz     = 2'd0;
    tick;
    uart_renable = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    tick;
    rx_valid = 1'b0;
    check("pp_rdone", {31'd0, uart_rdone}, 32'd1);
    check("pp_rd", uart_rd, 32'h00000020);
    check("pp_overrun", {31'd0, rx_overrun}, 32'd0);
    push_byte(8'h77);
    check("pp_refull_ovr", {31'd0, rx_overrun}, 32'd1);
    do_reset;

    // overrun on 17th byte, first 16 preserved in order
    for (int i = 0; i < 17; i++) begin
      push_byte(8'h10 + 8'(i));
      if (i == 15) check("ovr_before", {31'd0, rx_overrun}, 32'd0);
    end
    check("ovr_after", {31'd0, rx_overrun}, 32'd1);
    for (int i = 0; i < 16; i++) do_read(2'd0, {24'd0, 8'h10 + 8'(i)});
    check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);

    // reset in the middle of a write
    push_byte(8'h55);
    tx_ready     = 1'b1;
    uart_wenable = 1'b1;
    uart_wsz     = 2'd3;
    uart_wd      = 32'h11223344;
    tick;
    uart_wenable = 1'b0;
    tick;
    tick;
    check("mid_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("mid_tx_data", {24'd0, tx_data}, {24'd0, exp_w4[23:16]});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tx_ready = 1'b0;
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_wdone", {31'd0, uart_wdone}, 32'd0);
    check("abort_overrun", {31'd0, rx_overrun}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("abort_no_wdone", {31'd0, uart_wdone}, 32'd0);
    end
    uart_renable = 1'b1;
    uart_rsz     = 2'd0;
    tick;
    uart_renable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_fifo_empty", {31'd0, uart_rdone}, 32'd0);
      tick;
    end
    push_byte(8'h3C);
    tick;
    check("abort_rdone", {31'd0, uart_rdone}, 32'd1);
    check("abort_rd", uart_rd, 32'h0000003C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
